tcm_psk8_mapper: RTL

//   Transmit-side 8PSK mapper for the 4D-8PSK TCM chain: sits after tcm_enc, converts 3-bit symbol

---
 rtl/tcm_psk8_mapper_pkg.sv | 47 ++++
 rtl/tcm_psk8_mapper_lut.sv | 29 ++
 rtl/tcm_psk8_mapper.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tcm_psk8_mapper_pkg.sv
// Shared types and constellation constants for the 8PSK mapper.
// Amplitudes scale with the sample width so the decoder input range is kept.
package tcm_psk8_mapper_pkg;

    localparam int unsigned MAX_DAT_W = 16;

    typedef enum logic [0:0] {
        StIdle,
        StInPkt
    } state_e;

    typedef struct packed {
        logic signed [MAX_DAT_W-1:0] re;
        logic signed [MAX_DAT_W-1:0] im;
    } cmplx_dat_t;

    function automatic int ref_amp(input int unsigned dat_w);
        return 1 << (dat_w - 2);
    endfunction

    // round(REF / sqrt(2)) using fixed-point integer arithmetic
    function automatic int diag_amp(input int unsigned dat_w);
        longint r;
        r = longint'(ref_amp(dat_w)) * 64'sd70710678 + 64'sd50000000;
        return int'(r / 64'sd100000000);
    endfunction

    function automatic cmplx_dat_t psk8_point(input logic [2:0] k, input int unsigned dat_w);
        logic signed [MAX_DAT_W-1:0] a;
        logic signed [MAX_DAT_W-1:0] d;
        cmplx_dat_t p;
        a = MAX_DAT_W'(ref_amp(dat_w));
        d = MAX_DAT_W'(diag_amp(dat_w));
        case (k)
            3'd0:    p = '{re: a,  im: '0};
            3'd1:    p = '{re: d,  im: d};
            3'd2:    p = '{re: '0, im: a};
            3'd3:    p = '{re: -d, im: d};
            3'd4:    p = '{re: -a, im: '0};
            3'd5:    p = '{re: -d, im: -d};
            3'd6:    p = '{re: '0, im: -a};
            default: p = '{re: d,  im: -d};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tcm_psk8_mapper_lut.sv
// Registered symbol-index to I/Q table; output holds its value between valid symbols.
module tcm_psk8_mapper_lut
    import tcm_psk8_mapper_pkg::*;
#(
    parameter int unsigned pDAT_W = 12
) (
    input  logic       iclk,
    input  logic       ireset,
    input  logic       iclkena,
    input  logic       ival,
    input  logic [2:0] ik,
    output cmplx_dat_t odat
);

    cmplx_dat_t point;

    always_comb begin
        point = psk8_point(ik, pDAT_W);
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            odat <= '0;
        end else if (iclkena && ival) begin
            odat <= point;
        end
    end

endmodule

// File: rtl/tcm_psk8_mapper.sv
// 8PSK mapper: per-packet rotation, 2-cycle I/Q pipeline, framing FSM and symbol counter.
module tcm_psk8_mapper
    import tcm_psk8_mapper_pkg::*;
#(
    parameter int unsigned pDAT_W = 12,
    parameter int unsigned pCNT_W = 16
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              i1sps,
    input  logic              isop,
    input  logic              ieop,
    input  logic              ival,
    input  logic [2:0]        idat,
    input  logic [2:0]        iphase,
    output logic              o1sps,
    output logic              osop,
    output logic              oeop,
    output logic              oval,
    output logic [pDAT_W-1:0] odat_re,
    output logic [pDAT_W-1:0] odat_im,
    output logic [pCNT_W-1:0] osym_cnt,
    output logic              oframe_err
);

    state_e            state_q, state_d;
    logic [2:0]        rot_q, rot_d;
    logic [pCNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic              err_d;
    logic [2:0]        k_d;

    logic              val1_q, sop1_q, eop1_q, sps1_q, err1_q;
    logic [2:0]        k1_q;
    logic              val2_q, sop2_q, eop2_q, sps2_q, err2_q;
    cmplx_dat_t        lut_dat;

    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + pCNT_W'(1);
        // a new sop takes its own phase immediately, not the previous packet's
        k_d     = idat + ((ival && isop) ? iphase : rot_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rot_d   = rot_q;
        err_d   = 1'b0;
        if (ival) begin
            if (isop) begin
                rot_d   = iphase;
                cnt_d   = pCNT_W'(1);
                err_d   = (state_q == StInPkt);
                state_d = ieop ? StIdle : StInPkt;
            end else if (state_q == StInPkt) begin
                cnt_d = cnt_inc;
                if (ieop) begin
                    state_d = StIdle;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q <= StIdle;
            rot_q   <= '0;
            cnt_q   <= '0;
            val1_q  <= 1'b0;
            sop1_q  <= 1'b0;
            eop1_q  <= 1'b0;
            sps1_q  <= 1'b0;
            err1_q  <= 1'b0;
            k1_q    <= '0;
            val2_q  <= 1'b0;
            sop2_q  <= 1'b0;
            eop2_q  <= 1'b0;
            sps2_q  <= 1'b0;
            err2_q  <= 1'b0;
        end else if (iclkena) begin
            state_q <= state_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
            val1_q  <= ival;
            sop1_q  <= ival & isop;
            eop1_q  <= ival & ieop;
            sps1_q  <= i1sps;
            err1_q  <= err_d;
            k1_q    <= k_d;
            val2_q  <= val1_q;
            sop2_q  <= sop1_q;
            eop2_q  <= eop1_q;
            sps2_q  <= sps1_q;
            err2_q  <= err1_q;
        end
    end

    tcm_psk8_mapper_lut #(
        .pDAT_W (pDAT_W)
    ) u_lut (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (val1_q),
        .ik      (k1_q),
        .odat    (lut_dat)
    );

    always_comb begin
        oval       = val2_q;
        osop       = sop2_q & val2_q;
        oeop       = eop2_q & val2_q;
        o1sps      = sps2_q;
        oframe_err = err2_q;
        odat_re    = pDAT_W'(lut_dat.re);
        odat_im    = pDAT_W'(lut_dat.im);
        osym_cnt   = cnt_q;
    end

endmodule
